// File: rtl/ov5640_cfg_pkg.sv
// Shared types and constants for the OV5640 register-write sequencer.
package ov5640_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM_RD,
        S_DECODE,
        S_ISSUE,
        S_WAIT_ACC,
        S_WAIT_DONE,
        S_DELAY
    } cfg_state_t;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] addr;
    } rom_word_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFFE;

    localparam logic [1:0] CAM0     = 2'b01;
    localparam logic [1:0] CAM1     = 2'b10;
    localparam logic [1:0] CAM_BOTH = 2'b11;

    function automatic logic all_ready(input logic [1:0] rdy, input logic [1:0] mask);
        return (rdy & mask) == mask;
    endfunction

    function automatic logic all_busy(input logic [1:0] rdy, input logic [1:0] mask);
        return (rdy & mask) == 2'b00;
    endfunction

endpackage

// File: rtl/ov5640_cfg_delay.sv
// Loadable tick down-counter; one tick every DELAY_UNIT enabled cycles.
module ov5640_cfg_delay #(
    parameter int DELAY_UNIT = 50000
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_load,
    input  logic [7:0] i_ticks,
    input  logic       i_en,
    output logic       o_done
);
    localparam int PW = (DELAY_UNIT > 1) ? $clog2(DELAY_UNIT) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DELAY_UNIT - 1);

    logic [PW-1:0] r_pre;
    logic [7:0]    r_ticks;
    logic          w_tick;

    assign w_tick = (r_pre == PRE_LAST);
    // Asserted on the last counted cycle so the caller spends exactly ticks*DELAY_UNIT cycles waiting.
    assign o_done = (r_ticks == 8'd0) || ((r_ticks == 8'd1) && w_tick);

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_pre   <= '0;
            r_ticks <= 8'd0;
        end else if (i_load) begin
            r_pre   <= '0;
            r_ticks <= i_ticks;
        end else if (i_en && (r_ticks != 8'd0)) begin
            if (w_tick) begin
                r_pre   <= '0;
                r_ticks <= r_ticks - 8'd1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ov5640_cfg_sequencer.sv
// Sequences OV5640 register writes from an init ROM table and HPS requests onto two SCCB masters.
module ov5640_cfg_sequencer
    import ov5640_cfg_pkg::*;
#(
    parameter int ROM_AW     = 8,
    parameter int DELAY_UNIT = 50000
) (
    input  logic              i_clk_sys,
    input  logic              i_reset,
    input  logic              i_init_start,
    input  logic [1:0]        i_init_cam_mask,
    output logic              o_init_busy,
    output logic              o_init_done,
    output logic [ROM_AW-1:0] o_rom_addr,
    input  logic [23:0]       i_rom_q,
    input  logic              i_hps_valid,
    input  logic [15:0]       i_hps_addr,
    input  logic [7:0]        i_hps_data,
    input  logic [1:0]        i_hps_cam_mask,
    output logic              o_hps_ack,
    output logic [1:0]        o_sccb_start,
    output logic [15:0]       o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    input  logic [1:0]        i_sccb_ready
);
    cfg_state_t        r_state, w_state_nxt;
    logic [ROM_AW-1:0] r_rom_addr, w_rom_addr_nxt;
    logic              r_init_busy, w_init_busy_nxt;
    logic              r_init_done, w_init_done_nxt;
    logic              r_hps_ack, w_hps_ack_nxt;
    logic [1:0]        r_sccb_start, w_sccb_start_nxt;
    logic [15:0]       r_sccb_addr, w_sccb_addr_nxt;
    logic [7:0]        r_sccb_data, w_sccb_data_nxt;
    logic [1:0]        r_mask, w_mask_nxt;
    logic [1:0]        r_init_mask, w_init_mask_nxt;
    logic              w_dly_load, w_dly_done;
    logic              w_complete, w_advance;
    rom_word_t         w_rom;

    assign w_rom = rom_word_t'(i_rom_q);

    ov5640_cfg_delay #(.DELAY_UNIT(DELAY_UNIT)) u_delay (
        .i_clk_sys (i_clk_sys),
        .i_reset   (i_reset),
        .i_load    (w_dly_load),
        .i_ticks   (w_rom.data),
        .i_en      (r_state == S_DELAY),
        .o_done    (w_dly_done)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_rom_addr_nxt   = r_rom_addr;
        w_init_busy_nxt  = r_init_busy;
        w_init_done_nxt  = 1'b0;
        w_hps_ack_nxt    = 1'b0;
        w_sccb_start_nxt = 2'b00;
        w_sccb_addr_nxt  = r_sccb_addr;
        w_sccb_data_nxt  = r_sccb_data;
        w_mask_nxt       = r_mask;
        w_init_mask_nxt  = r_init_mask;
        w_dly_load       = 1'b0;
        w_complete       = 1'b0;
        w_advance        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_init_start) begin
                    w_init_mask_nxt = i_init_cam_mask;
                    w_rom_addr_nxt  = '0;
                    w_init_busy_nxt = 1'b1;
                    w_state_nxt     = S_ROM_RD;
                end else if (i_hps_valid) begin
                    w_sccb_addr_nxt = i_hps_addr;
                    w_sccb_data_nxt = i_hps_data;
                    w_mask_nxt      = i_hps_cam_mask;
                    w_hps_ack_nxt   = 1'b1;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ROM_RD: w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (w_rom.addr == CFG_END) begin
                    w_init_busy_nxt = 1'b0;
                    w_init_done_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (w_rom.addr == CFG_DELAY) begin
                    if (w_rom.data == 8'd0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_dly_load  = 1'b1;
                        w_state_nxt = S_DELAY;
                    end
                end else begin
                    w_sccb_addr_nxt = w_rom.addr;
                    w_sccb_data_nxt = w_rom.data;
                    w_mask_nxt      = r_init_mask;
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // An empty mask addresses no camera, so the write retires without a handshake.
                if (r_mask == 2'b00) begin
                    w_complete = 1'b1;
                end else if (all_ready(i_sccb_ready, r_mask)) begin
                    w_sccb_start_nxt = r_mask;
                    w_state_nxt      = S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (all_busy(i_sccb_ready, r_mask)) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (all_ready(i_sccb_ready, r_mask)) w_complete = 1'b1;
            end
            S_DELAY: begin
                if (w_dly_done) w_advance = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_complete) begin
            if (r_init_busy) w_advance = 1'b1;
            else             w_state_nxt = S_IDLE;
        end

        // Running off the top of the ROM closes the table exactly like an end marker.
        if (w_advance) begin
            if (&r_rom_addr) begin
                w_init_busy_nxt = 1'b0;
                w_init_done_nxt = 1'b1;
                w_state_nxt     = S_IDLE;
            end else begin
                w_rom_addr_nxt = r_rom_addr + 1'b1;
                w_state_nxt    = S_ROM_RD;
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_rom_addr   <= '0;
            r_init_busy  <= 1'b0;
            r_init_done  <= 1'b0;
            r_hps_ack    <= 1'b0;
            r_sccb_start <= 2'b00;
            r_sccb_addr  <= 16'd0;
            r_sccb_data  <= 8'd0;
            r_mask       <= 2'b00;
            r_init_mask  <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_rom_addr   <= w_rom_addr_nxt;
            r_init_busy  <= w_init_busy_nxt;
            r_init_done  <= w_init_done_nxt;
            r_hps_ack    <= w_hps_ack_nxt;
            r_sccb_start <= w_sccb_start_nxt;
            r_sccb_addr  <= w_sccb_addr_nxt;
            r_sccb_data  <= w_sccb_data_nxt;
            r_mask       <= w_mask_nxt;
            r_init_mask  <= w_init_mask_nxt;
        end
    end

    assign o_init_busy  = r_init_busy;
    assign o_init_done  = r_init_done;
    assign o_rom_addr   = r_rom_addr;
    assign o_hps_ack    = r_hps_ack;
    assign o_sccb_start = r_sccb_start;
    assign o_sccb_addr  = r_sccb_addr;
    assign o_sccb_data  = r_sccb_data;

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Bench for ov5640_cfg_sequencer: ROM model, two SCCB master models, write-list reference model.
module tb_ov5640_cfg_sequencer;
    import ov5640_cfg_pkg::*;

    localparam int AW = 3;
    localparam int DU = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_start = 1'b0;
    logic [1:0]  init_cam_mask = 2'b00;
    logic        init_busy, init_done;
    logic [AW-1:0] rom_addr;
    logic [23:0] rom_q = 24'h0;
    logic        hps_valid = 1'b0;
    logic [15:0] hps_addr = 16'h0;
    logic [7:0]  hps_data = 8'h0;
    logic [1:0]  hps_cam_mask = 2'b00;
    logic        hps_ack;
    logic [1:0]  sccb_start;
    logic [15:0] sccb_addr;
    logic [7:0]  sccb_data;
    logic [1:0]  sccb_ready;

    ov5640_cfg_sequencer #(.ROM_AW(AW), .DELAY_UNIT(DU)) dut (
        .i_clk_sys       (clk),
        .i_reset         (reset),
        .i_init_start    (init_start),
        .i_init_cam_mask (init_cam_mask),
        .o_init_busy     (init_busy),
        .o_init_done     (init_done),
        .o_rom_addr      (rom_addr),
        .i_rom_q         (rom_q),
        .i_hps_valid     (hps_valid),
        .i_hps_addr      (hps_addr),
        .i_hps_data      (hps_data),
        .i_hps_cam_mask  (hps_cam_mask),
        .o_hps_ack       (hps_ack),
        .o_sccb_start    (sccb_start),
        .o_sccb_addr     (sccb_addr),
        .o_sccb_data     (sccb_data),
        .i_sccb_ready    (sccb_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Synchronous ROM, one cycle read latency.
    logic [23:0] rom [0:7];
    always @(posedge clk) rom_q <= rom[rom_addr];

    // Master models: ready drops 1-3 cycles after a start, stays low 10 cycles.
    logic [1:0] mrdy = 2'b11;
    logic [1:0] hold_low = 2'b00;
    int drop [2];
    int busy [2];
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                mrdy[c] <= 1'b1; drop[c] <= 0; busy[c] <= 0;
            end else if (sccb_start[c]) begin
                drop[c] <= int'($urandom_range(1, 3));
            end else if (drop[c] > 0) begin
                drop[c] <= drop[c] - 1;
                if (drop[c] == 1) begin mrdy[c] <= 1'b0; busy[c] <= 10; end
            end else if (busy[c] > 0) begin
                busy[c] <= busy[c] - 1;
                if (busy[c] == 1) mrdy[c] <= 1'b1;
            end
        end
    end
    assign sccb_ready = mrdy & ~hold_low;

    // Monitor
    typedef struct {
        logic [1:0]  m;
        logic [15:0] a;
        logic [7:0]  d;
        int          t;
    } wr_t;
    wr_t wq[$];
    wr_t exp_q[$];
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, ack_cnt = 0, ack_while_busy = 0;
    int ack_cyc[$];
    int addr_cyc [8];
    logic busy_at_done = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (sccb_start != 2'b00) wq.push_back('{sccb_start, sccb_addr, sccb_data, cyc});
            if (init_done) begin done_cnt++; done_cyc = cyc; busy_at_done = init_busy; end
            if (hps_ack) begin ack_cnt++; ack_cyc.push_back(cyc); end
            if (hps_ack && init_busy) ack_while_busy++;
            if (rom_addr != prev_addr) addr_cyc[rom_addr] = cyc;
            prev_addr = rom_addr;
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic clear_mon();
        wq.delete(); ack_cyc.delete();
        done_cnt = 0; ack_cnt = 0;
    endtask

    // Reference: walk the table, skip delays, stop at end marker or after the last entry.
    task automatic build_init_exp(input logic [1:0] m);
        logic [15:0] a;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            a = rom[i][15:0];
            if (a == CFG_END) break;
            if (a != CFG_DELAY && m != 2'b00) exp_q.push_back('{m, a, rom[i][23:16], 0});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; step(); step();
        checks++;
        if ({init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data} !== '0)
            begin errors++; $display("FAIL reset_outputs got %h exp 0",
                {init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data}); end
        reset = 1'b0; step();
    endtask

    task automatic test_init_table();
        for (int i = 0; i < 8; i++) rom[i] = 24'h0;
        rom[0] = {8'h82, 16'h3008}; rom[1] = {8'd3, CFG_DELAY};
        rom[2] = {8'h11, 16'h3103}; rom[3] = {8'h00, CFG_END};
        build_init_exp(CAM_BOTH); clear_mon();
        init_cam_mask = CAM_BOTH; init_start = 1'b1; step(); init_start = 1'b0;
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL init_busy_rise got %b exp 1", init_busy); end
        for (int k = 0; k < 400 && done_cnt == 0; k++) step();
        repeat (4) step();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL init_done_count got %0d exp 1", done_cnt); end
        checks++;
        if (busy_at_done !== 1'b0) begin errors++; $display("FAIL init_busy_fall got %b exp 0", busy_at_done); end
        checks++;
        if (addr_cyc[2] - addr_cyc[1] !== 2 + 3 * DU)
            begin errors++; $display("FAIL delay_gap got %0d exp %0d", addr_cyc[2] - addr_cyc[1], 2 + 3 * DU); end
        checks++;
        if (wq.size() !== exp_q.size()) begin errors++; $display("FAIL init_wr_count got %0d exp %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (wq[i].m !== exp_q[i].m || wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d)
                begin errors++; $display("FAIL init_wr%0d got %b/%h/%h exp %b/%h/%h", i,
                    wq[i].m, wq[i].a, wq[i].d, exp_q[i].m, exp_q[i].a, exp_q[i].d); end
        end
    endtask

    task automatic test_random_init();
        logic [1:0] m;
        int kind;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 8; i++) begin
                kind = int'($urandom_range(0, 9));
                if (kind == 0)     rom[i] = {8'h00, CFG_END};
                else if (kind < 3) rom[i] = {8'($urandom_range(0, 3)), CFG_DELAY};
                else               rom[i] = {8'($urandom), 16'(16'h3000 + $urandom_range(0, 4095))};
            end
            m = 2'($urandom_range(0, 3));
            build_init_exp(m); clear_mon();
            init_cam_mask = m; init_start = 1'b1; step(); init_start = 1'b0;
            for (int k = 0; k < 1500 && done_cnt == 0; k++) step();
            repeat (3) step();
            checks++;
            if (done_cnt !== 1) begin errors++; $display("FAIL rnd%0d_done got %0d exp 1", it, done_cnt); end
            checks++;
            if (wq.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_wr_count got %0d exp %0d", it, wq.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++;
                if (wq[i].m !== exp_q[i].m || wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d)
                    begin errors++; $display("FAIL rnd%0d_wr%0d got %b/%h/%h exp %b/%h/%h", it, i,
                        wq[i].m, wq[i].a, wq[i].d, exp_q[i].m, exp_q[i].a, exp_q[i].d); end
            end
        end
    endtask

    task automatic test_hps();
        logic [15:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
        int req, bad;
        bit dropped, fin;
        for (int n = 0; n < 5; n++) begin
            if (n == 0) begin a = 16'h4300; d = 8'h30; m = CAM0; end
            else begin a = 16'($urandom_range(0, 16'hFFFD)); d = 8'($urandom); m = 2'($urandom_range(1, 3)); end
            clear_mon();
            hps_addr = a; hps_data = d; hps_cam_mask = m; hps_valid = 1'b1; req = cyc;
            for (int k = 0; k < 10 && ack_cnt == 0; k++) step();
            hps_valid = 1'b0;
            checks++;
            if (ack_cyc.size() == 0 || ack_cyc[0] - req !== 1)
                begin errors++; $display("FAIL hps%0d_ack_latency got %0d exp 1", n, ack_cyc.size() ? ack_cyc[0] - req : -1); end
            bad = 0; dropped = 0; fin = 0;
            for (int k = 0; k < 40 && !fin; k++) begin
                step();
                if (wq.size() > 0) begin
                    if (sccb_addr !== a || sccb_data !== d) bad++;
                    if ((sccb_ready & m) == 2'b00) dropped = 1;
                    else if (dropped && (sccb_ready & m) == m) fin = 1;
                end
            end
            checks++;
            if (wq.size() !== 1 || wq[0].m !== m || wq[0].a !== a || wq[0].d !== d || wq[0].t - req !== 2)
                begin errors++; $display("FAIL hps%0d_start got n=%0d exp 1 start %b %h/%h at +2", n, wq.size(), m, a, d); end
            checks++;
            if (bad !== 0 || !fin) begin errors++; $display("FAIL hps%0d_hold got bad=%0d fin=%0d exp 0/1", n, bad, fin); end
            repeat (3) step();
            checks++;
            if (ack_cnt !== 1) begin errors++; $display("FAIL hps%0d_ack_pulse got %0d exp 1", n, ack_cnt); end
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 8; i++) rom[i] = 24'h0;
        rom[0] = {8'h82, 16'h3008}; rom[1] = {8'h11, 16'h3103}; rom[2] = {8'h00, CFG_END};
        build_init_exp(CAM1);
        exp_q.push_back('{CAM0, 16'h5000, 8'hAA, 0});
        clear_mon();
        init_cam_mask = CAM1; hps_addr = 16'h5000; hps_data = 8'hAA; hps_cam_mask = CAM0;
        init_start = 1'b1; hps_valid = 1'b1; step(); init_start = 1'b0;
        for (int k = 0; k < 600 && ack_cnt == 0; k++) step();
        hps_valid = 1'b0;
        repeat (25) step();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL tie_done got %0d exp 1", done_cnt); end
        checks++;
        if (ack_cnt !== 1 || ack_cyc[0] <= done_cyc)
            begin errors++; $display("FAIL tie_ack_order got acks=%0d exp 1 after done cycle %0d", ack_cnt, done_cyc); end
        checks++;
        if (wq.size() !== exp_q.size()) begin errors++; $display("FAIL tie_wr_count got %0d exp %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (wq[i].m !== exp_q[i].m || wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d)
                begin errors++; $display("FAIL tie_wr%0d got %b/%h/%h exp %b/%h/%h", i,
                    wq[i].m, wq[i].a, wq[i].d, exp_q[i].m, exp_q[i].a, exp_q[i].d); end
        end
    endtask

    task automatic test_ready_stall();
        int rel;
        clear_mon();
        hold_low = CAM1;
        hps_addr = 16'h3820; hps_data = 8'h41; hps_cam_mask = CAM_BOTH; hps_valid = 1'b1;
        for (int k = 0; k < 10 && ack_cnt == 0; k++) step();
        hps_valid = 1'b0;
        repeat (20) step();
        checks++;
        if (wq.size() !== 0) begin errors++; $display("FAIL stall_no_start got %0d starts exp 0", wq.size()); end
        hold_low = 2'b00; rel = cyc;
        for (int k = 0; k < 10 && wq.size() == 0; k++) step();
        checks++;
        if (wq.size() !== 1 || wq[0].m !== CAM_BOTH || wq[0].t <= rel)
            begin errors++; $display("FAIL stall_release got n=%0d exp 1 start 11 after cycle %0d", wq.size(), rel); end
        repeat (25) step();
        // Empty-mask request immediately followed by a cam0 request.
        clear_mon();
        hps_addr = 16'h1111; hps_data = 8'h22; hps_cam_mask = 2'b00; hps_valid = 1'b1;
        for (int k = 0; k < 10 && ack_cnt == 0; k++) step();
        hps_addr = 16'h2222; hps_data = 8'h33; hps_cam_mask = CAM0;
        for (int k = 0; k < 10 && ack_cnt < 2; k++) step();
        hps_valid = 1'b0;
        repeat (25) step();
        checks++;
        if (ack_cnt !== 2 || ack_cyc[1] - ack_cyc[0] > 3)
            begin errors++; $display("FAIL mask0_turnaround got acks=%0d exp 2 within 3 cycles", ack_cnt); end
        checks++;
        if (wq.size() !== 1 || wq[0].m !== CAM0 || wq[0].a !== 16'h2222)
            begin errors++; $display("FAIL mask0_no_start got n=%0d exp 1 start for 2222", wq.size()); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) rom[i] = 24'h0;
        rom[0] = {8'h82, 16'h3008}; rom[1] = {8'd200, CFG_DELAY};
        rom[2] = {8'h11, 16'h3103}; rom[3] = {8'h00, CFG_END};
        clear_mon();
        init_cam_mask = CAM_BOTH; init_start = 1'b1; step(); init_start = 1'b0;
        for (int k = 0; k < 50 && wq.size() == 0; k++) step();
        repeat (5) step();
        reset = 1'b1; step();
        checks++;
        if ({init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data} !== '0)
            begin errors++; $display("FAIL reset_wait_done got %h exp 0",
                {init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data}); end
        reset = 1'b0; step();
        clear_mon();
        init_start = 1'b1; step(); init_start = 1'b0;
        for (int k = 0; k < 100 && rom_addr !== 3'd1; k++) step();
        repeat (6) step();
        reset = 1'b1; step();
        checks++;
        if ({init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data} !== '0)
            begin errors++; $display("FAIL reset_delay got %h exp 0",
                {init_busy, init_done, rom_addr, hps_ack, sccb_start, sccb_addr, sccb_data}); end
        reset = 1'b0; step();
        rom[1] = {8'd1, CFG_DELAY};
        build_init_exp(CAM_BOTH); clear_mon();
        init_start = 1'b1; step(); init_start = 1'b0;
        for (int k = 0; k < 400 && done_cnt == 0; k++) step();
        repeat (3) step();
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL restart_done got %0d exp 1", done_cnt); end
        checks++;
        if (wq.size() !== exp_q.size()) begin errors++; $display("FAIL restart_wr_count got %0d exp %0d", wq.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (wq[i].m !== exp_q[i].m || wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d)
                begin errors++; $display("FAIL restart_wr%0d got %b/%h/%h exp %b/%h/%h", i,
                    wq[i].m, wq[i].a, wq[i].d, exp_q[i].m, exp_q[i].a, exp_q[i].d); end
        end
    endtask

    task automatic test_wrap();
        logic [1:0] m;
        for (int i = 0; i < 8; i++) rom[i] = {8'($urandom), 16'(16'h3800 + i)};
        m = 2'($urandom_range(1, 3));
        build_init_exp(m); clear_mon();
        init_cam_mask = m; init_start = 1'b1; step(); init_start = 1'b0;
        for (int k = 0; k < 600 && done_cnt == 0; k++) step();
        repeat (5) step();
        checks++;
        if (done_cnt !== 1 || init_busy !== 1'b0)
            begin errors++; $display("FAIL wrap_done got done=%0d busy=%b exp 1/0", done_cnt, init_busy); end
        checks++;
        if (wq.size() !== 8) begin errors++; $display("FAIL wrap_wr_count got %0d exp 8", wq.size()); end
        else foreach (exp_q[i]) begin
            checks++;
            if (wq[i].m !== exp_q[i].m || wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d)
                begin errors++; $display("FAIL wrap_wr%0d got %b/%h/%h exp %b/%h/%h", i,
                    wq[i].m, wq[i].a, wq[i].d, exp_q[i].m, exp_q[i].a, exp_q[i].d); end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom[i] = 24'h0;
        test_reset();
        test_init_table();
        test_random_init();
        test_hps();
        test_tie();
        test_ready_stall();
        test_reset_mid();
        test_wrap();
        checks++;
        if (ack_while_busy !== 0) begin errors++; $display("FAIL ack_during_init got %0d exp 0", ack_while_busy); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
